dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder serving load/store requests from the MEM stage of the pipelined MIPS CPU. It replaces the zero-wait-state data memory with a word-addressed, register-based array behind a request/busy/valid handshake. `busy` lets the hazard unit stall the pipeline while an access is in flight.

## Interface

Parameters:
- `WORD_LEN`, default `WORD_LEN` from defines.v (32): data and address width.
- `DEPTH_LOG2`, default 8: array holds 2^DEPTH_LOG2 words.
- `WAIT_STATES`, default 2, legal range 0..7: extra array-access cycles per request.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `reqRead`, input, 1: load request from MEM stage.
- `reqWrite`, input, 1: store request from MEM stage.
- `address`, input, WORD_LEN: byte address (ALU result).
- `dataIn`, input, WORD_LEN: store value.
- `dataOut`, output, WORD_LEN: registered load data.
- `busy`, output, 1: pipeline stall request.
- `valid`, output, 1: one-cycle completion pulse.
- `error`, output, 1: misaligned-access flag. Tied to 0 unless the feature in Configuration is enabled.

## Operation

- Word index is `address[DEPTH_LOG2+1:2]`. Higher address bits are ignored, so accesses alias modulo the array size.
- State machine has three states: IDLE, WAIT, RESP.
- **IDLE**
  - On `reqRead | reqWrite`: latch `address`, `dataIn` and op, load counter with `WAIT_STATES`, go to WAIT.
  - If `reqRead` and `reqWrite` are both high, the request is a write (write priority).
- **WAIT**
  - Counter ≠ 0: decrement and stay in WAIT.
  - Counter = 0: perform the access at this edge and go to RESP.
    - Write: array[idx] ← latched data.
    - Read: dataOut ← array[idx].
- **RESP**
  - `valid` = 1, `busy` = 0.
  - Request inputs are not sampled; this cycle belongs to the completing request.
  - Next state is IDLE unconditionally.
- `busy` = (IDLE & (reqRead | reqWrite)) | WAIT. It is combinational on the request in IDLE so the stall applies in the issuing cycle.
- `dataOut` changes only on read completion. It holds its value across writes and idle cycles.
- Latched address and data are used for the access, so input changes after the issue cycle are ignored.

## Timing

- Request sampled in IDLE at cycle 0.
  - `busy` high in cycles 0..WAIT_STATES+1.
  - `valid` high in cycle WAIT_STATES+2.
  - Read data is on `dataOut` from cycle WAIT_STATES+2 and holds until the next read completes.
- Example, WAIT_STATES=0: busy in cycles 0–1, valid in cycle 2.
- Back-to-back requests: a request presented in the cycle after RESP is accepted immediately. Throughput is one access per WAIT_STATES+3 cycles.
- Reset values:
  - `dataOut` = 0, `busy` = 0, `valid` = 0, `error` = 0.
  - State IDLE, counter 0.
  - All array words cleared to 0.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A pending write is discarded and the array is cleared.

## Configuration

- Macro `DMEM_ALIGN_CHECK_EN`.
- **Defined:**
  - `address[1:0]` ≠ 0 at request acceptance marks the request misaligned.
  - The request follows identical timing.
  - A misaligned write does not modify the array.
  - A misaligned read leaves `dataOut` unchanged.
  - `error` = 1 in the RESP cycle, coincident with `valid`, and 0 otherwise.
- **Undefined:** `address[1:0]` is ignored and `error` is constant 0.

## Test plan

- **Reset:** assert `rst` asynchronously mid-cycle → `busy`/`valid`/`dataOut` = 0 immediately; a read of word 5 afterwards returns 0.
- **Write then read, WAIT_STATES=2:** write 0xDEADBEEF to address 0x14, then read 0x14 → `busy` high 4 cycles each; `valid` in cycle 4 of each access; `dataOut` = 0xDEADBEEF from the read's cycle 4.
- **Simultaneous reqRead+reqWrite:** address 0x8, dataIn 0x12345678 → treated as write; `dataOut` unchanged; a subsequent read of 0x8 returns 0x12345678.
- **Aliasing, DEPTH_LOG2=8:** write 0xA5A5A5A5 to 0x400 → a read of 0x000 returns 0xA5A5A5A5.
- **Reset during WAIT of a write to 0x20 with 0xCAFEF00D:** → no `valid` pulse; a read of 0x20 afterwards returns 0.
- **With `DMEM_ALIGN_CHECK_EN`:** write 0x11111111 to 0x22 → `error` = 1 with `valid`; a read of 0x20 returns the prior value 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory behind a request/busy/valid handshake.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int WORD_LEN    = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reqRead,
    input  logic                reqWrite,
    input  logic [WORD_LEN-1:0] address,
    input  logic [WORD_LEN-1:0] dataIn,
    output logic [WORD_LEN-1:0] dataOut,
    output logic                busy,
    output logic                valid,
    output logic                error
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state;
    logic [2:0]            cnt_p0;
    logic [DEPTH_LOG2-1:0] idx_p0;
    logic [WORD_LEN-1:0]   data_p0;
    logic                  wr_p0;
    logic                  mis_p0;
    logic                  vld_p1;
    logic                  err_p1;
    logic [WORD_LEN-1:0]   mem [DEPTH];

    logic                  req;
    logic                  misaligned_in;
    logic                  unused_addr_bits;

    assign req = reqRead | reqWrite;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned_in    = |address[1:0];
    assign unused_addr_bits = ^address[WORD_LEN-1:DEPTH_LOG2+2];
`else
    assign misaligned_in    = 1'b0;
    assign unused_addr_bits = ^{address[WORD_LEN-1:DEPTH_LOG2+2], address[1:0]};
`endif

    // Stall is raised in the issuing cycle itself, so it cannot wait for a register.
    assign busy = !rst && (((state == S_IDLE) && req) || (state == S_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt_p0  <= '0;
            idx_p0  <= '0;
            data_p0 <= '0;
            wr_p0   <= 1'b0;
            mis_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            dataOut <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            case (state)
                // Issue: capture the request so later input changes are ignored
                S_IDLE: begin
                    if (req) begin
                        idx_p0  <= address[DEPTH_LOG2+1:2];
                        data_p0 <= dataIn;
                        wr_p0   <= reqWrite;
                        mis_p0  <= misaligned_in;
                        cnt_p0  <= WAIT_LOAD;
                        state   <= S_WAIT;
                    end
                end
                // Array access happens on the edge where the wait counter is exhausted
                S_WAIT: begin
                    if (cnt_p0 != 3'd0) begin
                        cnt_p0 <= cnt_p0 - 3'd1;
                    end else begin
                        if (!mis_p0) begin
                            if (wr_p0) begin
                                mem[idx_p0] <= data_p0;
                            end else begin
                                dataOut <= mem[idx_p0];
                            end
                        end
                        vld_p1 <= 1'b1;
                        err_p1 <= mis_p0;
                        state  <= S_RESP;
                    end
                end
                // Response: inputs are not sampled in this cycle
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign valid = vld_p1;
    assign error = err_p1;

endmodule
